// File: rtl/ej32_dc_seq.sv
// ej32_dc_seq: table-driven decoder sequencer for the eJ32 core.
// Holds the opcode/phase registers and steps each bytecode through its phases.
// Ports: clk, rst (async, active-low), data/mem_rdy (memory byte bus),
//   bsy (per-unit busy flags), code/phase (EJ32_CTL bus), en (unit enables,
//   bit0 AU, bit1 BR, bit2 LS), p_inc (PC advance), op_err (illegal opcode),
//   stall_cnt (saturating stall counter, only with EJ32_DC_STALL_CNT_EN).
module ej32_dc_seq #(
   parameter int NUNIT = 3,
   parameter int PW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data,
   input  logic             mem_rdy,
   input  logic [NUNIT-1:0] bsy,
   output logic [7:0]       code,
   output logic [PW-1:0]    phase,
   output logic [NUNIT-1:0] en,
   output logic             p_inc,
   output logic             op_err
`ifdef EJ32_DC_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {M_SINGLE, M_STEP, M_WAIT, M_BUSY} mode_t;

   typedef struct packed {
      mode_t      mode;
      logic [2:0] last;
      logic [2:0] mask;
      logic       ill;
   } dec_t;

   // The longest table entry (iaload) needs a last phase of 5.
   if (NUNIT < 3) begin : g_nunit_chk
      $error("ej32_dc_seq: NUNIT must be at least 3");
   end
   if (PW < 3) begin : g_pw_chk
      $error("ej32_dc_seq: PW too small for last phase 5");
   end

   function automatic dec_t decode(input logic [7:0] op);
      dec_t d;
      d = '{mode: M_SINGLE, last: 3'd0, mask: 3'b000, ill: 1'b0};
      unique case (1'b1)
         (op == 8'h00):                     d.mask = 3'b000;
         (op inside {[8'h01:8'h08]}):       d.mask = 3'b001;
         (op inside {8'h57, 8'h59, 8'h5F}): d.mask = 3'b001;
         (op inside {[8'h60:8'h82]} &&
          op != 8'h6C && op != 8'h70):      d.mask = 3'b001;
         (op inside {[8'h1A:8'h1D]}):       d.mask = 3'b011;
         (op == 8'hA9):                     d.mask = 3'b010;
         (op == 8'h10):
            d = '{mode: M_STEP, last: 3'd1, mask: 3'b001, ill: 1'b0};
         (op == 8'hB1):
            d = '{mode: M_STEP, last: 3'd1, mask: 3'b010, ill: 1'b0};
         (op == 8'h11):
            d = '{mode: M_STEP, last: 3'd2, mask: 3'b001, ill: 1'b0};
         (op inside {[8'h99:8'hA7]}):
            d = '{mode: M_STEP, last: 3'd2, mask: 3'b011, ill: 1'b0};
         (op == 8'h33):
            d = '{mode: M_WAIT, last: 3'd2, mask: 3'b100, ill: 1'b0};
         (op == 8'h54):
            d = '{mode: M_WAIT, last: 3'd2, mask: 3'b101, ill: 1'b0};
         (op == 8'h84):
            d = '{mode: M_WAIT, last: 3'd2, mask: 3'b111, ill: 1'b0};
         (op == 8'h2E):
            d = '{mode: M_WAIT, last: 3'd5, mask: 3'b100, ill: 1'b0};
         (op == 8'h6C || op == 8'h70):
            d = '{mode: M_BUSY, last: 3'd1, mask: 3'b001, ill: 1'b0};
         default: d.ill = 1'b1;
      endcase
      return d;
   endfunction

   dec_t          cur;
   dec_t          nxt;
   logic [PW-1:0] last_p;
   logic          busy_wait;
   logic          done;
   logic [7:0]    code_d;
   logic [PW-1:0] phase_d;
   logic          err_d;
   logic          err_q;
   logic          unused;

   assign cur    = decode(code);
   assign nxt    = decode(data);
   assign last_p = PW'(cur.last);
   assign unused = ^{bsy[NUNIT-1:1], nxt.mode, nxt.last, nxt.mask};

   // Divider parks in phase 1 until its busy flag drops.
   assign busy_wait = (cur.mode == M_BUSY) && (phase == PW'(1)) && bsy[0];

   always_comb begin
      code_d  = code;
      phase_d = phase;
      err_d   = 1'b0;
      en      = '0;
      p_inc   = 1'b0;
      if (cur.mode == M_BUSY)
         done = (phase == PW'(1)) && !bsy[0];
      else
         done = (phase == last_p);
      if (mem_rdy) begin
         en = NUNIT'(cur.mask);
         unique case (cur.mode)
            M_WAIT:  p_inc = done;
            M_BUSY:  p_inc = done;
            default: p_inc = 1'b1;
         endcase
         if (done) begin
            code_d  = data;
            phase_d = '0;
            err_d   = nxt.ill;
         end else if (!busy_wait) begin
            phase_d = phase + PW'(1);
         end
      end
      if (!rst) begin
         en    = '0;
         p_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code  <= 8'h00;
         phase <= '0;
         err_q <= 1'b0;
      end else begin
         code  <= code_d;
         phase <= phase_d;
         err_q <= err_d;
      end
   end

   assign op_err = err_q & mem_rdy;

`ifdef EJ32_DC_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (!mem_rdy && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ej32_dc_seq.sv
// tb_ej32_dc_seq: directed self-checking bench for ej32_dc_seq.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_ej32_dc_seq;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       mem_rdy;
   logic [2:0] bsy;
   logic [7:0] code;
   logic [2:0] phase;
   logic [2:0] en;
   logic       p_inc;
   logic       op_err;
`ifdef EJ32_DC_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int nvec = 0;
   int nerr = 0;

   ej32_dc_seq #(.NUNIT(3), .PW(3)) dut (
      .clk(clk),
      .rst(rst),
      .data(data),
      .mem_rdy(mem_rdy),
      .bsy(bsy),
      .code(code),
      .phase(phase),
      .en(en),
      .p_inc(p_inc),
      .op_err(op_err)
`ifdef EJ32_DC_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [7:0] d, input logic mr,
                      input logic [2:0] b);
      @(negedge clk);
      data    = d;
      mem_rdy = mr;
      bsy     = b;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] c,
                          input logic [2:0] ph, input logic [2:0] e,
                          input logic pi);
      chk({tag, ".code"}, 32'(code), 32'(c));
      chk({tag, ".phase"}, 32'(phase), 32'(ph));
      chk({tag, ".en"}, 32'(en), 32'(e));
      chk({tag, ".p_inc"}, 32'(p_inc), 32'(pi));
   endtask

   initial begin
      rst     = 1'b0;
      data    = 8'h00;
      mem_rdy = 1'b1;
      bsy     = 3'b000;
      repeat (2) @(negedge clk);
      #1;
      chk_out("rst", 8'h00, 3'd0, 3'b000, 1'b0);
      chk("rst.op_err", 32'(op_err), 32'd0);
`ifdef EJ32_DC_STALL_CNT_EN
      chk("rst.stall_cnt", stall_cnt, 32'd0);
`endif

      // nop completes, latching iconst_1
      @(negedge clk);
      rst  = 1'b1;
      data = 8'h04;
      #1;
      chk_out("nop", 8'h00, 3'd0, 3'b000, 1'b1);

      cyc(8'h60, 1'b1, 3'b000);
      chk_out("iconst_1", 8'h04, 3'd0, 3'b001, 1'b1);
      cyc(8'h11, 1'b1, 3'b000);
      chk_out("iadd", 8'h60, 3'd0, 3'b001, 1'b1);

      // sipush + two operand bytes, then iaload latched
      cyc(8'hAA, 1'b1, 3'b000);
      chk_out("sipush0", 8'h11, 3'd0, 3'b001, 1'b1);
      cyc(8'hBB, 1'b1, 3'b000);
      chk_out("sipush1", 8'h11, 3'd1, 3'b001, 1'b1);
      cyc(8'h2E, 1'b1, 3'b000);
      chk_out("sipush2", 8'h11, 3'd2, 3'b001, 1'b1);

      // iaload: five waiting phases then advance
      for (int i = 0; i < 6; i++) begin
         cyc((i == 5) ? 8'h6C : 8'h00, 1'b1, 3'b000);
         chk_out($sformatf("iaload%0d", i), 8'h2E, 3'(i), 3'b100,
                 (i == 5));
      end

      // idiv: phase 0, then 4 busy cycles in phase 1, then complete
      cyc(8'h00, 1'b1, 3'b000);
      chk_out("idiv0", 8'h6C, 3'd0, 3'b001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(8'h00, 1'b1, 3'b001);
         chk_out($sformatf("idiv_bsy%0d", i), 8'h6C, 3'd1, 3'b001, 1'b0);
      end
      cyc(8'h10, 1'b1, 3'b000);
      chk_out("idiv_done", 8'h6C, 3'd1, 3'b001, 1'b1);

      // bipush with a 3-cycle memory stall in phase 1
      cyc(8'h55, 1'b1, 3'b000);
      chk_out("bipush0", 8'h10, 3'd0, 3'b001, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(8'hFE, 1'b0, 3'b000);
         chk_out($sformatf("stall%0d", i), 8'h10, 3'd1, 3'b000, 1'b0);
         chk($sformatf("stall%0d.op_err", i), 32'(op_err), 32'd0);
      end
      cyc(8'hFE, 1'b1, 3'b000);
      chk_out("bipush1", 8'h10, 3'd1, 3'b001, 1'b1);
`ifdef EJ32_DC_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'd3);
`endif

      // illegal opcode 0xFE
      cyc(8'h2E, 1'b1, 3'b000);
      chk_out("illegal", 8'hFE, 3'd0, 3'b000, 1'b1);
      chk("illegal.op_err", 32'(op_err), 32'd1);

      // iaload aborted by reset in phase 3
      cyc(8'h00, 1'b1, 3'b000);
      chk_out("ab0", 8'h2E, 3'd0, 3'b100, 1'b0);
      chk("ab0.op_err", 32'(op_err), 32'd0);
      cyc(8'h00, 1'b1, 3'b000);
      cyc(8'h00, 1'b1, 3'b000);
      cyc(8'h00, 1'b1, 3'b000);
      chk_out("ab3", 8'h2E, 3'd3, 3'b100, 1'b0);
      rst = 1'b0;
      #1;
      chk_out("abrst", 8'h00, 3'd0, 3'b000, 1'b0);
      chk("abrst.op_err", 32'(op_err), 32'd0);
`ifdef EJ32_DC_STALL_CNT_EN
      chk("abrst.stall_cnt", stall_cnt, 32'd0);
`endif

      // restart: nop completes, then iload_0 (AU|BR)
      @(negedge clk);
      rst  = 1'b1;
      data = 8'h1A;
      #1;
      chk_out("re_nop", 8'h00, 3'd0, 3'b000, 1'b1);
      cyc(8'h00, 1'b1, 3'b000);
      chk_out("iload_0", 8'h1A, 3'd0, 3'b011, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
